u_icache: RTL and testbench

U_ICACHE -- requirements
Module: u_icache

---
 rtl/u_icache_pkg.sv | 15 +
 rtl/u_icache_tag_array.sv | 45 ++++
 rtl/u_icache.sv | 129 ++++++++++++
 tb/tb_u_icache.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/u_icache_pkg.sv
// Shared types and geometry constants for the direct-mapped instruction cache.
package u_icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_OFFSET_W   = $clog2(DEF_LINE_WORDS);
    localparam int DEF_INDEX_W    = $clog2(DEF_LINES);
    localparam int DEF_TAG_W      = 30 - DEF_OFFSET_W - DEF_INDEX_W;

endpackage

// File: rtl/u_icache_tag_array.sv
// Tag and valid storage with combinational hit compare; valid bits are async-cleared and flash-clearable.
module u_icache_tag_array
    import u_icache_pkg::*;
#(
    parameter int LINES   = DEF_LINES,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    input  logic               write_en,
    input  logic [INDEX_W-1:0] write_index,
    input  logic [TAG_W-1:0]   write_tag,
    input  logic               clear_all
);

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tags_r [LINES];

    // Valid bits; a clear-all wins over a simultaneous line write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (clear_all) begin
            valid_r <= '0;
        end else if (write_en) begin
            valid_r[write_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            tags_r[write_index] <= write_tag;
        end
    end

    assign hit = valid_r[lookup_index] && (tags_r[lookup_index] == lookup_tag);

endmodule

// File: rtl/u_icache.sv
// Direct-mapped blocking instruction cache with in-order line refill and fence.i flush.
module u_icache
    import u_icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:2] address_i,
    output logic [31:0] read_data_o,
    output logic        busywait_o,
    input  logic        flush_i,
    output logic        mem_read_o,
    output logic [31:2] mem_address_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_valid_i
);

    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = 30 - OFFSET_W - INDEX_W;
    localparam int LINE_W   = TAG_W + INDEX_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);
    localparam logic [OFFSET_W-1:0] BEAT_ONE  = OFFSET_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic [LINE_W-1:0]   miss_line_r;
    logic [OFFSET_W-1:0] beat_cnt_r;
    logic                flush_pending_r;
    logic [31:0]         data_r [LINES][LINE_WORDS];

    logic [OFFSET_W-1:0] offset_s;
    logic [INDEX_W-1:0]  index_s;
    logic [TAG_W-1:0]    tag_s;
    logic [INDEX_W-1:0]  miss_index_s;
    logic [TAG_W-1:0]    miss_tag_s;
    logic                hit_s;
    logic                beat_valid_s;
    logic                last_beat_s;
    logic                clear_all_s;

    assign offset_s     = address_i[OFFSET_W+1:2];
    assign index_s      = address_i[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign tag_s        = address_i[31:OFFSET_W+INDEX_W+2];
    assign miss_index_s = miss_line_r[INDEX_W-1:0];
    assign miss_tag_s   = miss_line_r[LINE_W-1:INDEX_W];

    assign beat_valid_s = (state_r == REFILL) && mem_valid_i;
    assign last_beat_s  = beat_valid_s && (beat_cnt_r == LAST_BEAT);
    // A flush seen during refill is deferred so it also kills the line being filled.
    assign clear_all_s  = ((state_r == IDLE) && flush_i)
                        || (last_beat_s && (flush_pending_r || flush_i));

    u_icache_tag_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .lookup_index (index_s),
        .lookup_tag   (tag_s),
        .hit          (hit_s),
        .write_en     (last_beat_s),
        .write_index  (miss_index_s),
        .write_tag    (miss_tag_s),
        .clear_all    (clear_all_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!hit_s) begin
                    state_s = REFILL;
                end else begin
                    state_s = IDLE;
                end
            end
            REFILL: begin
                if (last_beat_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = REFILL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM, miss latch, beat counter and deferred-flush flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r         <= IDLE;
            miss_line_r     <= '0;
            beat_cnt_r      <= '0;
            flush_pending_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && !hit_s) begin
                miss_line_r <= {tag_s, index_s};
                beat_cnt_r  <= '0;
            end else if (beat_valid_s) begin
                beat_cnt_r  <= beat_cnt_r + BEAT_ONE;
            end
            if (last_beat_s) begin
                flush_pending_r <= 1'b0;
            end else if ((state_r == REFILL) && flush_i) begin
                flush_pending_r <= 1'b1;
            end
        end
    end

    // Line data storage, written one beat at a time; never reset.
    always_ff @(posedge clk_i) begin
        if (beat_valid_s) begin
            data_r[miss_index_s][beat_cnt_r] <= mem_readdata_i;
        end
    end

    assign read_data_o   = data_r[index_s][offset_s];
    assign busywait_o    = (state_r == REFILL) || !hit_s;
    assign mem_read_o    = (state_r == REFILL);
    assign mem_address_o = (state_r == REFILL) ? {miss_line_r, beat_cnt_r} : 30'h0;

endmodule

// File: tb/tb_u_icache.sv
// Self-checking bench for u_icache: vector table of fetches plus flush and reset corner sequences.
module tb_u_icache;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:2] address_i;
    logic [31:0] read_data_o;
    logic        busywait_o;
    logic        flush_i;
    logic        mem_read_o;
    logic [31:2] mem_address_o;
    logic [31:0] mem_readdata_i;
    logic        mem_valid_i;

    int tests = 0;
    int fails = 0;
    int gap_div = 1;
    int gap_cnt = 0;
    int beat_seen = 0;
    logic noise_en = 1'b0;
    logic [29:0] exp_beats [$];
    logic [31:0] exp_data [$];

    typedef struct {
        logic [29:0] addr;
        int          gap;
        int          stall;
    } vec_t;
    vec_t vecs [12];

    u_icache dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .address_i      (address_i),
        .read_data_o    (read_data_o),
        .busywait_o     (busywait_o),
        .flush_i        (flush_i),
        .mem_read_o     (mem_read_o),
        .mem_address_o  (mem_address_o),
        .mem_readdata_i (mem_readdata_i),
        .mem_valid_i    (mem_valid_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] k;
        if (a >= 30'h10 && a <= 30'h13) begin
            k = {2'b00, a} - 32'h0000_000F;
            return k * 32'h0000_0011;
        end
        return {2'b11, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Backing memory: answers every gap_div-th request cycle, pops the expected beat order.
    always @(negedge clk_i) begin
        if (mem_read_o) begin
            gap_cnt = gap_cnt + 1;
            if (gap_cnt >= gap_div) begin
                gap_cnt        = 0;
                mem_valid_i    = 1'b1;
                mem_readdata_i = mem_word(mem_address_o);
                beat_seen++;
                if (exp_beats.size() == 0)
                    check("unexpected_beat", {2'b00, mem_address_o}, 32'hFFFF_FFFF);
                else
                    check("beat_addr", {2'b00, mem_address_o}, {2'b00, exp_beats.pop_front()});
            end else begin
                mem_valid_i    = 1'b0;
                mem_readdata_i = 32'hBAD0_0000;
            end
        end else begin
            gap_cnt        = 0;
            mem_valid_i    = noise_en;
            mem_readdata_i = 32'hBAD0_BAD0;
        end
    end

    task automatic fetch(input logic [29:0] a, input int stall, input string nm);
        int n = 0;
        address_i = a;
        beat_seen = 0;
        if (stall > 0)
            for (int k = 0; k < 4; k++) exp_beats.push_back({a[29:2], 2'(k)});
        exp_data.push_back(mem_word(a));
        #1;
        while (busywait_o && n < 100) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check({nm, "_stall"}, n, stall);
        check({nm, "_data"}, read_data_o, exp_data.pop_front());
        check({nm, "_beats"}, beat_seen, (stall > 0) ? 4 : 0);
        @(negedge clk_i);
    endtask

    initial begin
        vecs[0]  = '{30'h10,         1, 5};
        vecs[1]  = '{30'h11,         1, 0};
        vecs[2]  = '{30'h12,         1, 0};
        vecs[3]  = '{30'h13,         1, 0};
        vecs[4]  = '{30'h10,         1, 0};
        vecs[5]  = '{30'h110,        1, 5};
        vecs[6]  = '{30'h10,         1, 5};
        vecs[7]  = '{30'h3F3,        1, 5};
        vecs[8]  = '{30'h3FFF_FFF2,  1, 5};
        vecs[9]  = '{30'h40,         3, 13};
        vecs[10] = '{30'h43,         1, 0};
        vecs[11] = '{30'h3F3,        1, 5};

        rst_i          = 1'b0;
        address_i      = 30'h10;
        flush_i        = 1'b0;
        mem_valid_i    = 1'b0;
        mem_readdata_i = 32'h0000_0000;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_mem_read", {31'h0, mem_read_o}, 32'h0);
        check("rst_mem_addr", {2'b00, mem_address_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        address_i = 30'h3FFF_FFFF;
        #1;
        check("cold_busy_hi", {31'h0, busywait_o}, 32'h1);

        noise_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            gap_div = vecs[i].gap;
            fetch(vecs[i].addr, vecs[i].stall, $sformatf("vec%0d", i));
        end
        noise_en = 1'b0;
        gap_div  = 1;

        // Flush while idle on a hit line: everything must miss afterwards.
        address_i = 30'h10;
        flush_i   = 1'b1;
        #1;
        check("pre_flush_hit", {31'h0, busywait_o}, 32'h0);
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("post_flush_busy", {31'h0, busywait_o}, 32'h1);
        fetch(30'h10, 5, "flush_refetch");
        fetch(30'h43, 5, "flush_other_line");

        // Flush arriving on beat 2 of a refill.
        fetch(30'h110, 5, "evict");
        address_i = 30'h10;
        beat_seen = 0;
        for (int k = 0; k < 4; k++) exp_beats.push_back(30'h10 + 30'(k));
        repeat (3) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("flush_refill_beats", beat_seen, 4);
        check("flush_refill_busy", {31'h0, busywait_o}, 32'h1);
        check("flush_refill_idle", {31'h0, mem_read_o}, 32'h0);
        fetch(30'h10, 5, "flush_refill_again");

        // Reset asserted after beat 1 of a refill.
        address_i = 30'h60;
        for (int k = 0; k < 4; k++) exp_beats.push_back(30'h60 + 30'(k));
        repeat (3) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_abort_read", {31'h0, mem_read_o}, 32'h0);
        check("rst_abort_addr", {2'b00, mem_address_o}, 32'h0);
        check("rst_abort_busy", {31'h0, busywait_o}, 32'h1);
        exp_beats.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        fetch(30'h60, 5, "rst_refetch");
        fetch(30'h10, 5, "rst_cleared");

        check("beats_leftover", exp_beats.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
